// File: rtl/ring_pkg.sv
// Shared definitions for one-hot ring counter consumers: lock FSM states
// and word-level helpers. Helpers work on a fixed maximum-width container
// so any ring width up to RING_MAX_W can use them with a width argument.
package ring_pkg;

  localparam int RING_MAX_W = 64;

  // Lock state machine encoding.
  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } ring_state_e;

  // Rotate right by one within the low 'width' bits: bit i takes bit i+1,
  // the top bit of the ring takes bit 0. Bits above the ring stay zero.
  function automatic logic [RING_MAX_W-1:0] ror1(input logic [RING_MAX_W-1:0] word,
                                                 input int width);
    logic [RING_MAX_W-1:0] res;
    res = '0;
    for (int i = 0; i < RING_MAX_W - 1; i++) begin
      if (i < width - 1) res[i] = word[i+1];
    end
    res[width-1] = word[0];
    return res;
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_onehot(input logic [RING_MAX_W-1:0] word);
    return ($countones(word) == 1);
  endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// Combinational one-hot to binary decoder. 'idx' is only meaningful when
// 'is_onehot' is high; for other words it is the OR of set-bit positions.
module onehot_to_bin #(
  parameter  int WIDTH = 4,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] word,
  output logic [IDX_W-1:0] idx,
  output logic             is_onehot
);

  localparam int MW = ring_pkg::RING_MAX_W;

  // OR together the positions of every set bit.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (word[i]) idx = idx | IDX_W'(i);
    end
  end

  assign is_onehot = ring_pkg::is_onehot(MW'(word));

endmodule

// File: rtl/ring_sequence_checker.sv
// Receive-side monitor for a one-hot ring counter bus. Decodes each sampled
// word to an index, flags non-one-hot words and out-of-sequence steps, and
// runs a HUNT/LOCKED tracker that counts lock losses in a saturating counter.
//
// Handshake: there is no ready; ring_in is consumed on every rising edge
// where in_valid=1. With in_valid=0 nothing changes except that err_clr
// still clears err_count. All outputs are registered and describe the
// sample taken on the previous edge.
module ring_sequence_checker
  import ring_pkg::*;
#(
  parameter  int WIDTH     = 4,
  parameter  int LOCK_CNT  = 3,
  parameter  int ERR_CNT_W = 8,
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     ring_in,
  input  logic                 err_clr,
  output logic [IDX_W-1:0]     index,
  output logic                 index_valid,
  output logic                 onehot_err,
  output logic                 seq_err,
  output logic                 locked,
  output logic                 lost,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int                    MW          = RING_MAX_W;
  localparam int                    GOOD_W      = $clog2(LOCK_CNT + 1);
  localparam logic [GOOD_W-1:0]     GOOD_TARGET = GOOD_W'(LOCK_CNT);
  localparam logic [ERR_CNT_W-1:0]  ERR_MAX     = '1;

  // Tracker state.
  ring_state_e          state_q, state_n;
  logic                 have_ref_q, have_ref_n;
  logic [WIDTH-1:0]     ref_q, ref_n;
  logic [GOOD_W-1:0]    good_q, good_n, good_inc;

  // Next values for the registered outputs.
  logic [IDX_W-1:0]     index_n;
  logic                 index_valid_n, onehot_err_n, seq_err_n, lost_n;
  logic [ERR_CNT_W-1:0] err_count_n;
  logic                 err_inc;

  // Sample classification.
  logic [IDX_W-1:0]     dec_idx;
  logic                 dec_oh;
  logic [WIDTH-1:0]     ref_rot;
  logic                 match;

  onehot_to_bin #(.WIDTH(WIDTH)) u_dec (
    .word      (ring_in),
    .idx       (dec_idx),
    .is_onehot (dec_oh)
  );

  assign ref_rot  = WIDTH'(ror1(MW'(ref_q), WIDTH));
  assign match    = dec_oh && have_ref_q && (ring_in == ref_rot);
  assign good_inc = good_q + GOOD_W'(1);

  // The lock level is the FSM state itself, so it doubles as the state view.
  assign locked = (state_q == LOCKED);

  // Next-state logic for the tracker, decode outputs and error counter.
  always_comb begin
    state_n       = state_q;
    have_ref_n    = have_ref_q;
    ref_n         = ref_q;
    good_n        = good_q;
    index_n       = index;
    index_valid_n = 1'b0;
    onehot_err_n  = 1'b0;
    seq_err_n     = 1'b0;
    lost_n        = 1'b0;
    err_inc       = 1'b0;

    if (in_valid) begin
      if (dec_oh) begin
        index_n       = dec_idx;
        index_valid_n = 1'b1;
      end
      onehot_err_n = !dec_oh;
      seq_err_n    = dec_oh && have_ref_q && !match;

      case (state_q)
        HUNT: begin
          if (!dec_oh) begin
            have_ref_n = 1'b0;
            good_n     = '0;
          end else if (!match) begin
            ref_n      = ring_in;
            have_ref_n = 1'b1;
            good_n     = '0;
          end else begin
            ref_n = ring_in;
            if (good_inc == GOOD_TARGET) begin
              state_n = LOCKED;
              good_n  = '0;
            end else begin
              good_n = good_inc;
            end
          end
        end
        LOCKED: begin
          if (match) begin
            ref_n = ring_in;
          end else begin
            // Any failure drops lock; a one-hot failing word seeds the hunt.
            state_n = HUNT;
            lost_n  = 1'b1;
            err_inc = 1'b1;
            good_n  = '0;
            if (dec_oh) begin
              ref_n      = ring_in;
              have_ref_n = 1'b1;
            end else begin
              have_ref_n = 1'b0;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end

    // Clear beats a same-cycle increment; the count sticks at its maximum.
    if (err_clr)
      err_count_n = '0;
    else if (err_inc && (err_count != ERR_MAX))
      err_count_n = err_count + ERR_CNT_W'(1);
    else
      err_count_n = err_count;
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= HUNT;
      have_ref_q  <= 1'b0;
      ref_q       <= '0;
      good_q      <= '0;
      index       <= '0;
      index_valid <= 1'b0;
      onehot_err  <= 1'b0;
      seq_err     <= 1'b0;
      lost        <= 1'b0;
      err_count   <= '0;
    end else begin
      state_q     <= state_n;
      have_ref_q  <= have_ref_n;
      ref_q       <= ref_n;
      good_q      <= good_n;
      index       <= index_n;
      index_valid <= index_valid_n;
      onehot_err  <= onehot_err_n;
      seq_err     <= seq_err_n;
      lost        <= lost_n;
      err_count   <= err_count_n;
    end
  end

endmodule

// File: tb/tb_ring_sequence_checker.sv
// Bench for ring_sequence_checker: table of directed vectors, hand-written
// corner sequences, and randomized traffic against a position-based model.
module tb_ring_sequence_checker;

  localparam int WIDTH     = 4;
  localparam int LOCK_CNT  = 3;
  localparam int ERR_CNT_W = 2;
  localparam int IDX_W     = $clog2(WIDTH);
  localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic                 clock = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic [WIDTH-1:0]     ring_in;
  logic                 err_clr;
  logic [IDX_W-1:0]     index;
  logic                 index_valid, onehot_err, seq_err, locked, lost;
  logic [ERR_CNT_W-1:0] err_count;

  always #5 clock = ~clock;

  ring_sequence_checker #(
    .WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .ring_in     (ring_in),
    .err_clr     (err_clr),
    .index       (index),
    .index_valid (index_valid),
    .onehot_err  (onehot_err),
    .seq_err     (seq_err),
    .locked      (locked),
    .lost        (lost),
    .err_count   (err_count)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The ring is tracked as the position of its set bit: a correct step
  // moves that position down by one, wrapping from 0 to WIDTH-1.
  bit m_locked, m_have_ref;
  int m_ref_pos, m_good, m_index, m_ec;
  bit e_iv, e_oe, e_se, e_lost;

  task automatic model_reset();
    m_locked = 0; m_have_ref = 0; m_ref_pos = 0; m_good = 0;
    m_index = 0; m_ec = 0;
    e_iv = 0; e_oe = 0; e_se = 0; e_lost = 0;
  endtask

  task automatic model_step(input logic v, input logic [WIDTH-1:0] w, input logic clr);
    int ones, pos;
    bit oh, match, was_locked, inc;
    e_iv = 0; e_oe = 0; e_se = 0; e_lost = 0; inc = 0;
    was_locked = m_locked;
    if (v) begin
      ones = 0; pos = 0;
      for (int i = 0; i < WIDTH; i++) if (w[i]) begin ones++; pos = i; end
      oh    = (ones == 1);
      match = oh && m_have_ref && (pos == (m_ref_pos + WIDTH - 1) % WIDTH);
      if (oh) begin m_index = pos; e_iv = 1; end
      e_oe = !oh;
      e_se = oh && m_have_ref && !match;
      if (match) begin
        m_ref_pos = pos;
        if (!was_locked) begin
          m_good++;
          if (m_good == LOCK_CNT) begin m_locked = 1; m_good = 0; end
        end
      end else begin
        m_good = 0;
        if (oh) begin m_ref_pos = pos; m_have_ref = 1; end
        else m_have_ref = 0;
        if (was_locked) begin m_locked = 0; e_lost = 1; inc = 1; end
      end
    end
    if (clr) m_ec = 0;
    else if (inc && m_ec < ERR_MAX) m_ec++;
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; outputs are sampled one falling
  // edge later, i.e. after the rising edge that consumed the inputs.
  task automatic step(input logic v, input logic [WIDTH-1:0] w, input logic clr,
                      input string tag);
    in_valid = v; ring_in = w; err_clr = clr;
    model_step(v, w, clr);
    @(posedge clock);
    @(negedge clock);
    check({tag, " index"},       int'(index),       m_index);
    check({tag, " index_valid"}, int'(index_valid), int'(e_iv));
    check({tag, " onehot_err"},  int'(onehot_err),  int'(e_oe));
    check({tag, " seq_err"},     int'(seq_err),     int'(e_se));
    check({tag, " locked"},      int'(locked),      int'(m_locked));
    check({tag, " lost"},        int'(lost),        int'(e_lost));
    check({tag, " err_count"},   int'(err_count),   m_ec);
  endtask

  task automatic do_reset(input logic v, input logic [WIDTH-1:0] w, input string tag);
    reset = 1; in_valid = v; ring_in = w; err_clr = 0;
    @(posedge clock);
    @(negedge clock);
    reset = 0; in_valid = 0; ring_in = '0;
    model_reset();
    check({tag, " index"},       int'(index),       0);
    check({tag, " index_valid"}, int'(index_valid), 0);
    check({tag, " onehot_err"},  int'(onehot_err),  0);
    check({tag, " seq_err"},     int'(seq_err),     0);
    check({tag, " locked"},      int'(locked),      0);
    check({tag, " lost"},        int'(lost),        0);
    check({tag, " err_count"},   int'(err_count),   0);
  endtask

  task automatic relock(input string tag);
    step(1, 4'b0001, 0, tag);
    step(1, 4'b1000, 0, tag);
    step(1, 4'b0100, 0, tag);
    step(1, 4'b0010, 0, tag);
    check({tag, " relocked"}, int'(locked), 1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic             v;
    logic [WIDTH-1:0] w;
    logic             clr;
    int               idx;
    logic             iv, oe, se, lk, lost;
    int               ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [WIDTH-1:0] w, int idx,
                              logic iv, logic oe, logic se, logic lk, logic ls, int ec);
    vec_t r;
    r.v = v; r.w = w; r.clr = 0; r.idx = idx;
    r.iv = iv; r.oe = oe; r.se = se; r.lk = lk; r.lost = ls; r.ec = ec;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [IDX_W-1:0] exp_q[$];

  // ---------------- test sequence ----------------
  initial begin
    int exp_ec[4];
    exp_ec = '{1, 2, 3, 3};
    reset = 1; in_valid = 0; ring_in = '0; err_clr = 0;
    model_reset();

    do_reset(0, '0, "reset");

    // Lock-in, illegal code, backward step and recovery.
    tbl.push_back(mk(1, 4'b0001, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1000, 3, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0100, 2, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0010, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0011, 1, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(1, 4'b0001, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'b1000, 3, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'b0100, 2, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'b0010, 1, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 4'b0001, 0, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 4'b1000, 3, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 4'b0100, 2, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 4'b1000, 3, 1, 0, 1, 0, 1, 2));
    tbl.push_back(mk(1, 4'b0100, 2, 1, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 4'b0010, 1, 1, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 4'b0001, 0, 1, 0, 0, 1, 0, 2));

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].w, tbl[i].clr, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d index", i),       int'(index),       tbl[i].idx);
      check($sformatf("tbl%0d index_valid", i), int'(index_valid), int'(tbl[i].iv));
      check($sformatf("tbl%0d onehot_err", i),  int'(onehot_err),  int'(tbl[i].oe));
      check($sformatf("tbl%0d seq_err", i),     int'(seq_err),     int'(tbl[i].se));
      check($sformatf("tbl%0d locked", i),      int'(locked),      int'(tbl[i].lk));
      check($sformatf("tbl%0d lost", i),        int'(lost),        int'(tbl[i].lost));
      check($sformatf("tbl%0d err_count", i),   int'(err_count),   tbl[i].ec);
    end

    // Gaps while locked: advance to ref 0010, then valid samples 5 cycles apart.
    step(1, 4'b1000, 0, "gap pre");
    step(1, 4'b0100, 0, "gap pre");
    step(1, 4'b0010, 0, "gap pre");
    begin
      logic [WIDTH-1:0] gap_words[3];
      int               gap_idx[3];
      gap_words = '{4'b0001, 4'b1000, 4'b0100};
      gap_idx   = '{0, 3, 2};
      for (int k = 0; k < 3; k++) begin
        step(1, gap_words[k], 0, "gap valid");
        check("gap index", int'(index), gap_idx[k]);
        check("gap lock", int'(locked), 1);
        for (int g = 0; g < 5; g++) begin
          step(0, 4'b1111, 0, "gap idle");
          check("gap idle pulses", int'({index_valid, onehot_err, seq_err, lost}), 0);
          check("gap idle index", int'(index), gap_idx[k]);
          check("gap idle lock", int'(locked), 1);
        end
      end
    end

    // Saturation and clear with a 2-bit counter.
    step(0, '0, 1, "clr idle");
    check("clr idle err_count", int'(err_count), 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 4'b0000, 0, "sat err");
      check($sformatf("sat err_count %0d", k), int'(err_count), exp_ec[k]);
      check($sformatf("sat lost %0d", k), int'(lost), 1);
      relock("sat relock");
    end
    step(1, 4'b0011, 1, "clr+err");
    check("clr+err err_count", int'(err_count), 0);
    check("clr+err lost", int'(lost), 1);

    // Reset mid-lock with a bad word presented.
    relock("pre reset");
    do_reset(1, 4'b0000, "reset mid-lock");

    // Randomized traffic against the model, with an index scoreboard.
    exp_q.delete();
    for (int n = 0; n < 600; n++) begin
      logic             v;
      logic [WIDTH-1:0] w;
      int               r;
      v = ($urandom_range(0, 9) < 8);
      r = $urandom_range(0, 19);
      if (r < 14 && m_have_ref)
        w = WIDTH'(1 << ((m_ref_pos + WIDTH - 1) % WIDTH));
      else if (r < 17)
        w = WIDTH'(1 << $urandom_range(0, WIDTH - 1));
      else
        w = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      step(v, w, ($urandom_range(0, 29) == 0), "rand");
      if (e_iv) exp_q.push_back(IDX_W'(m_index));
      if (index_valid) begin
        check("sb depth", exp_q.size(), 1);
        if (exp_q.size() > 0) check("sb index", int'(index), int'(exp_q.pop_front()));
      end
    end
    check("sb drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ring_sequence_checker.md
Name: ring_sequence_checker

Overview:
Receive-side monitor for the team's 4-bit-style one-hot ring counter bus. It samples a one-hot ring word and decodes it to a binary index. It checks that the word is a legal one-hot code and that each new word is the previous word rotated right by one position (0001→1000→0100→0010→0001). A lock state machine reports when the ring has been tracking cleanly, and lock losses are counted.

Parameters:
WIDTH, 4, ring width in bits; legal range 2 and up.
LOCK_CNT, 3, consecutive correct transitions needed to enter LOCKED; legal range 1 and up.
ERR_CNT_W, 8, width of the saturating error counter.
IDX_W (localparam), $clog2(WIDTH), index width.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  ring_in is sampled this cycle
ring_in  in  WIDTH  ring word under check
err_clr  in  1  synchronous clear of err_count
index  out  IDX_W  bit position of the last legal one-hot sample
index_valid  out  1  1-cycle pulse: index updated
onehot_err  out  1  1-cycle pulse: sample was not one-hot (popcount ≠ 1)
seq_err  out  1  1-cycle pulse: one-hot sample ≠ ror(reference)
locked  out  1  level: FSM in LOCKED
lost  out  1  1-cycle pulse: LOCKED→HUNT transition
err_count  out  ERR_CNT_W  saturating count of errors seen while LOCKED

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clock.
- Reset values: FSM=HUNT, have_ref=0, ref=0, good_cnt=0, index=0, and index_valid, onehot_err, seq_err, locked, lost all 0. err_count=0.
- Reset mid-operation: the next cycle shows all reset values, regardless of in_valid.
- All outputs are registered. Each output reflects the sample taken on the previous edge, giving 1-cycle latency.
- in_valid=0: no state change; all pulse outputs are 0; index, locked and err_count hold.
- Sample classification when in_valid=1:
  - oh = (popcount(ring_in)==1).
  - match = oh && have_ref && ring_in == ror1(ref), where ror1 means bit i takes bit i+1 and the MSB takes bit 0.
- If oh: index ← position of the set bit and index_valid pulses. If not oh: index holds.
- onehot_err pulses for every non-one-hot sample, in either state.
- seq_err pulses when oh && have_ref && !match, in either state.
- HUNT state:
  - not oh: have_ref←0, good_cnt←0.
  - oh && !match: ref←ring_in, have_ref←1, good_cnt←0.
  - match: ref←ring_in and good_cnt←good_cnt+1. If good_cnt+1==LOCK_CNT, go to LOCKED (locked=1 in the following cycle) and set good_cnt←0.
- LOCKED state:
  - match: ref←ring_in, stay in LOCKED.
  - Any error (onehot_err or seq_err condition): go to HUNT, pulse lost, and increment err_count.
  - The failing sample becomes the new ref if oh (have_ref=1, good_cnt=0). Otherwise have_ref←0.
- err_count:
  - Increments only on errors while LOCKED.
  - Saturates at 2^ERR_CNT_W−1.
  - err_clr sets it to 0; err_clr wins over a simultaneous increment.
- Errors while in HUNT are flagged but not counted.
- First sample after reset or after an all-zero sample: cannot produce seq_err because have_ref=0.

Decomposition:
- Package ring_pkg:
  - state enum {HUNT, LOCKED}.
  - function ror1(word).
  - function is_onehot(word).
- One natural sub-module: onehot_to_bin. It is combinational, parameter WIDTH, outputs idx[IDX_W] and is_onehot. It is reusable by other ring consumers.
- FSM, reference register, counters and output registers live in the top module.

Test Plan:
1. Lock-in: WIDTH=4, LOCK_CNT=3. After reset, drive 0001, 1000, 0100, 0010 on consecutive cycles with in_valid=1. Required: index 0, 3, 2, 1, each with index_valid; locked=1 the cycle after 0010; no error pulses; err_count=0.
2. Illegal code: while locked at ref 0010, drive 0011. Required next cycle: onehot_err=1, lost=1, locked=0, err_count=1, index holds 1, index_valid=0.
3. Backward step: while locked at ref 0100, drive 1000. Required: seq_err=1, lost=1, err_count+1, ref=1000, index=3. Then drive 0100, 0010, 0001: no errors, and locked re-asserts after 0001.
4. Gaps: while locked, alternate valid samples (0001, then 1000, then 0100) with 5 cycles of in_valid=0 between them. Required: locked stays 1, no pulses during gaps, index updates only after valid samples.
5. Saturation and clear, ERR_CNT_W=2:
   - Run four lock/error episodes. Required: err_count reads 1, 2, 3, 3.
   - Assert err_clr in the same cycle as a LOCKED error. Required: err_count=0 and lost still pulses.
6. Reset mid-lock: while locked, assert reset together with in_valid=1 and a bad word (0000). Required next cycle: all outputs at reset values, with onehot_err=0 and err_count=0.
